bank_queue_arbiter: RTL

- Round-robin scheduler that shares a single DRAM command issue port between NUM_QUEUES per-bank shift-register command queues.
- Each cycle it selects one eligible queue head, pops it, and registers the command into a one-entry output stage with a valid/ready handshake.
- Enforces a per-bank minimum spacing between issued commands (BANK_BUSY_CYCLES) using per-bank cooldown counters.
- Sits between the per-bank queues and the DRAM command/timing stage.

---
 rtl/bank_queue_arbiter.sv | 93 +++++++++
 1 files changed

// File: rtl/bank_queue_arbiter.sv
// Round-robin issue arbiter: picks one eligible per-bank queue head per cycle,
// applies per-bank cooldown and registers the command into a one-entry output stage.
module bank_queue_arbiter #(
  parameter int NUM_QUEUES       = 4,
  parameter int WIDTH            = 32,
  parameter int BANK_BUSY_CYCLES = 4,
  parameter int CNT_W            = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [NUM_QUEUES-1:0]         q_valid,
  input  logic [NUM_QUEUES*WIDTH-1:0]   q_data,
  output logic [NUM_QUEUES-1:0]         q_pop,
  output logic                          cmd_valid,
  output logic [WIDTH-1:0]              cmd_data,
  output logic [$clog2(NUM_QUEUES)-1:0] cmd_src,
  input  logic                          cmd_ready,
  output logic [NUM_QUEUES-1:0]         bank_busy
);

  localparam int IDX_W = $clog2(NUM_QUEUES);

  logic [CNT_W-1:0]      cnt [NUM_QUEUES];
  logic [WIDTH-1:0]      head [NUM_QUEUES];
  logic [NUM_QUEUES-1:0] eligible;
  logic [IDX_W-1:0]      rr_ptr;
  logic [IDX_W-1:0]      grant_idx;
  logic [IDX_W-1:0]      scan_idx;
  logic                  grant_found;
  logic                  load_ok;
  logic                  do_grant;

  always_comb begin
    for (int i = 0; i < NUM_QUEUES; i++) begin
      eligible[i]  = q_valid[i] && (cnt[i] == '0);
      bank_busy[i] = (cnt[i] != '0);
      head[i]      = q_data[i*WIDTH +: WIDTH];
    end
  end

  // Scan starts at rr_ptr; IDX_W-bit addition wraps because NUM_QUEUES is a power of two.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int k = 0; k < NUM_QUEUES; k++) begin
      scan_idx = rr_ptr + IDX_W'(k);
      if (!grant_found && eligible[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  // Handshake: a command transfers on any edge where cmd_valid && cmd_ready.
  // While cmd_valid && !cmd_ready the stage holds data/src stable; it may be
  // reloaded in the same cycle it is accepted (load_ok), giving 1 cmd/cycle.
  assign load_ok  = !cmd_valid || cmd_ready;
  assign do_grant = !rst && en && load_ok && grant_found;

  always_comb begin
    q_pop = '0;
    if (do_grant) q_pop[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_valid <= 1'b0;
      cmd_data  <= '0;
      cmd_src   <= '0;
      rr_ptr    <= '0;
      for (int i = 0; i < NUM_QUEUES; i++) cnt[i] <= '0;
    end else begin
      if (do_grant) begin
        cmd_valid <= 1'b1;
        cmd_data  <= head[grant_idx];
        cmd_src   <= grant_idx;
        rr_ptr    <= grant_idx + IDX_W'(1);
      end else if (load_ok) begin
        cmd_valid <= 1'b0;
      end
      // Reload on grant wins over the saturating decrement.
      for (int i = 0; i < NUM_QUEUES; i++) begin
        if (do_grant && (grant_idx == IDX_W'(i)))
          cnt[i] <= CNT_W'(BANK_BUSY_CYCLES);
        else if (cnt[i] != '0)
          cnt[i] <= cnt[i] - CNT_W'(1);
      end
    end
  end

endmodule
